// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: default widths
// and the controller state encoding.
package divider_pkg;

    localparam int DIVIDEND_W_DEF = 16;
    localparam int DIVISOR_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference when it
// does not borrow, and shift the resulting quotient bit in at the LSB.
module divider_step
    import divider_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic [DIVISOR_W:0]    rem,
    input  logic [DIVIDEND_W-1:0] quo,
    input  logic [DIVISOR_W-1:0]  den,
    output logic [DIVISOR_W:0]    rem_next,
    output logic [DIVIDEND_W-1:0] quo_next
);

    logic [DIVISOR_W+1:0] shifted;
    logic                 ge;

    // Trial subtract and select; the partial remainder is always below the
    // divisor, so the kept value fits back into DIVISOR_W+1 bits.
    always_comb begin
        shifted  = {rem, quo[DIVIDEND_W-1]};
        ge       = (shifted >= (DIVISOR_W+2)'(den));
        rem_next = ge ? (DIVISOR_W+1)'(shifted - (DIVISOR_W+2)'(den))
                      : (DIVISOR_W+1)'(shifted);
        quo_next = {quo[DIVIDEND_W-2:0], ge};
    end

endmodule

// File: rtl/divider_seq.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, MSB
// first. Divide-by-zero short-circuits to DONE with an all-ones quotient.
// Optional build macro DIVIDER_FASTPATH_EN: dividend < divisor finishes in
// one cycle with quotient 0; results are identical either way.
module divider_seq
    import divider_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int               CNT_W = $clog2(DIVIDEND_W) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIVIDEND_W - 1);

    state_t                state, state_nx;
    logic                  load, fin_iter, fin_zero, fin_fast;
    logic [DIVIDEND_W-1:0] quo, quo_step;
    logic [DIVISOR_W:0]    rem, rem_step;
    logic [DIVISOR_W-1:0]  den;
    logic [CNT_W-1:0]      cnt;

    assign busy = (state == ITER);
    assign done = (state == DONE);

    divider_step #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (DIVISOR_W)
    ) u_step (
        .rem      (rem),
        .quo      (quo),
        .den      (den),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and datapath controls; start is only looked at when idle
    // or finishing, which is what makes back-to-back operations possible.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        fin_iter = 1'b0;
        fin_zero = 1'b0;
        fin_fast = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (divisor == '0) begin
                        fin_zero = 1'b1;
                        state_nx = DONE;
                    end
`ifdef DIVIDER_FASTPATH_EN
                    else if (dividend < DIVIDEND_W'(divisor)) begin
                        fin_fast = 1'b1;
                        state_nx = DONE;
                    end
`endif
                    else begin
                        load     = 1'b1;
                        state_nx = ITER;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            ITER: begin
                if (cnt == LAST) begin
                    fin_iter = 1'b1;
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Working registers: capture operands on accept, iterate while in ITER.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo <= '0;
            rem <= '0;
            den <= '0;
            cnt <= '0;
        end else if (load) begin
            quo <= dividend;
            rem <= '0;
            den <= divisor;
            cnt <= '0;
        end else if (state == ITER) begin
            quo <= quo_step;
            rem <= rem_step;
            cnt <= cnt + 1'b1;
        end
    end

    // Result registers change only on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (fin_iter) begin
            quotient    <= quo_step;
            remainder   <= rem_step[DIVISOR_W-1:0];
            div_by_zero <= 1'b0;
        end else if (fin_zero) begin
            quotient    <= '1;
            remainder   <= dividend[DIVISOR_W-1:0];
            div_by_zero <= 1'b1;
        end else if (fin_fast) begin
            quotient    <= '0;
            remainder   <= dividend[DIVISOR_W-1:0];
            div_by_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_divider_seq;

    localparam int DW = 16;
    localparam int VW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          busy, done, div_by_zero;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;

    int checks = 0;
    int errors = 0;

    // observations from the last run_op
    logic [DW-1:0] o_q;
    logic [VW-1:0] o_r;
    logic          o_z;
    int            o_lat, o_busy;
    bit            o_stable, o_busy_first;

    divider_seq #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division; divide-by-zero returns all ones and
    // the low dividend bits. Latency counts edges from accept to done.
    function automatic void model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                  output logic [DW-1:0] q, output logic [VW-1:0] r,
                                  output logic z, output int lat);
        if (b == 0) begin
            q = '1; r = a[VW-1:0]; z = 1'b1; lat = 1;
        end else begin
            q = a / b; r = VW'(a % b); z = 1'b0; lat = DW + 1;
`ifdef DIVIDER_FASTPATH_EN
            if (a < DW'(b)) lat = 1;
`endif
        end
    endfunction

    // Issue one operation and wait (bounded) for done. chained=1 drives start
    // immediately, i.e. in the current cycle (used from a done cycle).
    task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit chained);
        logic [DW-1:0] pq;
        logic [VW-1:0] pr;
        logic          pz;
        if (!chained) @(negedge clk);
        pq = quotient; pr = remainder; pz = div_by_zero;
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        o_lat = 1; o_busy = 0; o_stable = 1'b1; o_busy_first = busy;
        while (!done && o_lat < 40) begin
            if (busy) o_busy++;
            if (quotient !== pq || remainder !== pr || div_by_zero !== pz) o_stable = 1'b0;
            @(posedge clk); #1;
            o_lat++;
        end
        o_q = quotient; o_r = remainder; o_z = div_by_zero;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b q=%h r=%h z=%b, required all zero",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'd50, 8'd5, 1'b1);
        checks++;
        if (o_q !== 16'd10 || o_r !== 8'd0 || o_lat !== 17) begin
            errors++;
            $display("FAIL first_after_reset: q=%0d r=%0d lat=%0d, required q=10 r=0 lat=17", o_q, o_r, o_lat);
        end
    endtask

    task automatic test_basic();
        run_op(16'd35, 8'd7, 1'b0);
        checks++;
        if (o_q !== 16'd5 || o_r !== 8'd0) begin
            errors++;
            $display("FAIL basic_35_7: q=%0d r=%0d, required q=5 r=0", o_q, o_r);
        end
        checks++;
        if (o_lat !== 17 || o_busy !== 16) begin
            errors++;
            $display("FAIL basic_timing: lat=%0d busy_cycles=%0d, required lat=17 busy=16", o_lat, o_busy);
        end
        checks++;
        if (!o_stable) begin
            errors++;
            $display("FAIL basic_hold: outputs changed before done, required stable");
        end
    endtask

    task automatic test_back_to_back();
        run_op(16'd65025, 8'd255, 1'b0);
        checks++;
        if (o_q !== 16'd255 || o_r !== 8'd0) begin
            errors++;
            $display("FAIL b2b_first: q=%0d r=%0d, required q=255 r=0", o_q, o_r);
        end
        run_op(16'd1400, 8'd14, 1'b1);
        checks++;
        if (o_busy_first !== 1'b1 || o_lat !== 17) begin
            errors++;
            $display("FAIL b2b_no_idle: busy_after_accept=%b lat=%0d, required busy=1 lat=17", o_busy_first, o_lat);
        end
        checks++;
        if (o_q !== 16'd100 || o_r !== 8'd0) begin
            errors++;
            $display("FAIL b2b_second: q=%0d r=%0d, required q=100 r=0", o_q, o_r);
        end
    endtask

    task automatic test_div_zero();
        run_op(16'd100, 8'd0, 1'b0);
        checks++;
        if (o_q !== 16'hFFFF || o_r !== 8'h64 || o_z !== 1'b1 || o_lat !== 1) begin
            errors++;
            $display("FAIL div_zero: q=%h r=%h z=%b lat=%0d, required q=ffff r=64 z=1 lat=1", o_q, o_r, o_z, o_lat);
        end
        run_op(16'd10, 8'd3, 1'b0);
        checks++;
        if (o_q !== 16'd3 || o_r !== 8'd1 || o_z !== 1'b0) begin
            errors++;
            $display("FAIL div_zero_clear: q=%0d r=%0d z=%b, required q=3 r=1 z=0", o_q, o_r, o_z);
        end
    endtask

    task automatic test_ignore_busy();
        int  lat;
        bit  extra;
        @(negedge clk);
        start = 1'b1; dividend = 16'd255; divisor = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            if (lat == 4) begin
                start = 1'b1; dividend = 16'd200; divisor = 8'd9;
            end else if (lat == 5) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        checks++;
        if (quotient !== 16'd255 || remainder !== 8'd0 || lat !== 17) begin
            errors++;
            $display("FAIL ignore_busy: q=%0d r=%0d lat=%0d, required q=255 r=0 lat=17", quotient, remainder, lat);
        end
        extra = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (busy || done) extra = 1'b1;
        end
        checks++;
        if (extra !== 1'b0) begin
            errors++;
            $display("FAIL ignore_busy_followup: activity=%b, required none", extra);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        @(negedge clk);
        start = 1'b1; dividend = 16'd1000; divisor = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_clear: busy=%b done=%b q=%h r=%h z=%b, required all zero",
                     busy, done, quotient, remainder, div_by_zero);
        end
        saw_done = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_done: done seen=%b, required 0", saw_done);
        end
        run_op(16'd1000, 8'd3, 1'b0);
        checks++;
        if (o_q !== 16'd333 || o_r !== 8'd1) begin
            errors++;
            $display("FAIL reset_mid_rerun: q=%0d r=%0d, required q=333 r=1", o_q, o_r);
        end
    endtask

    task automatic test_fastpath();
        logic [DW-1:0] eq;
        logic [VW-1:0] er;
        logic          ez;
        int            el;
        model(16'd3, 8'd25, eq, er, ez, el);
        run_op(16'd3, 8'd25, 1'b0);
        checks++;
        if (o_q !== 16'd0 || o_r !== 8'd3 || o_z !== 1'b0 || o_lat !== el) begin
            errors++;
            $display("FAIL small_dividend: q=%0d r=%0d z=%b lat=%0d, required q=0 r=3 z=0 lat=%0d",
                     o_q, o_r, o_z, o_lat, el);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] a, eq;
        logic [VW-1:0] b, er;
        logic          ez;
        int            el;
        bit            chained;
        for (int i = 0; i < 60; i++) begin
            a = DW'($urandom);
            b = VW'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    if (b != 0) a = DW'($urandom_range(0, int'(b)));
                3:       b = 8'd1;
                default: ;
            endcase
            chained = (i != 0) && ($urandom_range(0, 1) == 1);
            model(a, b, eq, er, ez, el);
            run_op(a, b, chained);
            checks++;
            if (o_q !== eq || o_r !== er || o_z !== ez || o_lat !== el) begin
                errors++;
                $display("FAIL random_%0d: %0d/%0d gave q=%0d r=%0d z=%b lat=%0d, required q=%0d r=%0d z=%b lat=%0d",
                         i, a, b, o_q, o_r, o_z, o_lat, eq, er, ez, el);
            end
            checks++;
            if (!o_stable) begin
                errors++;
                $display("FAIL random_hold_%0d: outputs changed before done, required stable", i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_ignore_busy();
        test_reset_mid();
        test_fastpath();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/divider_seq.md
DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 SHALL have parameter DIVIDEND_W, default 16: dividend and quotient width.
REQ-002 SHALL have parameter DIVISOR_W, default 8: divisor and remainder width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request; sampled only while busy=0.
REQ-006 SHALL have port dividend, input, DIVIDEND_W bits: unsigned dividend; captured when start is accepted.
REQ-007 SHALL have port divisor, input, DIVISOR_W bits: unsigned divisor; captured when start is accepted.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when results become valid.
REQ-010 SHALL have port quotient, output, DIVIDEND_W bits: unsigned result.
REQ-011 SHALL have port remainder, output, DIVISOR_W bits: unsigned result.
REQ-012 SHALL have port div_by_zero, output, 1 bit: last operation had divisor=0.

Function
REQ-013 SHALL implement a restoring divider that resolves one quotient bit per cycle, MSB first, using a partial remainder of DIVISOR_W+1 bits.
REQ-014 SHALL use the states IDLE, ITER and DONE, with these transitions:
- IDLE to ITER on an accepted start.
- ITER to DONE after DIVIDEND_W iterations, counted by a log2(DIVIDEND_W)+1-bit counter.
- DONE to IDLE after one cycle, unless start is accepted in that cycle.
REQ-015 SHALL accept start in IDLE or DONE, i.e. whenever busy=0; start while busy=1 SHALL be ignored, with no effect on state or captured operands.
REQ-016 SHALL, for start accepted at edge N with a nonzero divisor, assert done during the cycle after edge N+DIVIDEND_W; default latency is 17 cycles.
REQ-017 SHALL hold busy high from the edge after acceptance until the edge that enters DONE.
REQ-018 SHALL, for divisor=0, skip ITER and enter DONE on the next edge with:
- quotient = all ones;
- remainder = dividend[DIVISOR_W-1:0];
- div_by_zero=1.
REQ-019 SHALL hold quotient, remainder and div_by_zero stable from done until the next accepted start; they SHALL change only at done.
REQ-020 SHALL, for every legal operation, satisfy quotient*divisor+remainder == dividend and remainder < divisor.
REQ-021 SHALL accept a start in the same cycle as done (back-to-back); the new operation SHALL then proceed without an IDLE cycle.

Reset
REQ-022 SHALL, on rst_n low, immediately force state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clear the iteration counter.
REQ-023 SHALL, on reset during ITER, discard the operation and never assert done for it.
REQ-024 SHALL release from reset synchronously; the first start SHALL be accepted at the first rising edge after rst_n rises.

Configuration
REQ-025 SHALL implement macro DIVIDER_FASTPATH_EN.
- Defined: when a start is accepted with dividend < divisor (divisor nonzero), the block SHALL enter DONE on the next edge with quotient=0, remainder=dividend[DIVISOR_W-1:0] and latency 1.
- Undefined: all nonzero-divisor operations SHALL take the full DIVIDEND_W iterations.
- Results SHALL be identical in both builds.

Structure
REQ-026 SHALL place the default widths and the state encoding (IDLE=2'd0, ITER=2'd1, DONE=2'd2) in the shared package divider_pkg.
REQ-027 SHALL factor one restoring iteration (shift, trial subtract, select, quotient bit) into a combinational sub-module divider_step, instantiated once.

Verification
REQ-028 SHALL cover 35/7: quotient=5, remainder=0, done exactly 17 cycles after the start edge, busy high for 16 cycles.
REQ-029 SHALL cover 65025/255 followed back-to-back by 1400/14: quotient=255, remainder=0, then quotient=100, remainder=0, with no idle cycle between the operations.
REQ-030 SHALL cover 100/0: done 1 cycle later, quotient=16'hFFFF, remainder=8'h64, div_by_zero=1; a following 10/3 SHALL clear div_by_zero and give quotient=3, remainder=1.
REQ-031 SHALL cover start=1 with 200/9 pulsed at cycle 5 of a running 255/1: result SHALL be 255 remainder 0, and the second request SHALL be ignored.
REQ-032 SHALL cover rst_n low at cycle 8 of 1000/3: all outputs zero immediately, no done pulse, and a subsequent 1000/3 SHALL give 333 remainder 1.
REQ-033 SHALL cover 3/25 in both builds: quotient=0, remainder=3, latency 1 with DIVIDER_FASTPATH_EN and 17 without.
